servo_pwm_gen: RTL and testbench
================================

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 5, number of servo channels.
REQ-003 SHALL have parameter FRAME_US, default 20000, PWM frame period in us.
REQ-004 SHALL have parameters MIN_US = 1000, MAX_US = 2000 and INIT_US = 1500, giving the clamp limits and the reset pulse width in us.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit: width command present.
REQ-008 SHALL have port cmd_ready, output, 1 bit: block accepts the command this cycle.
REQ-009 SHALL have port cmd_ch, input, 3 bits: target channel index.
REQ-010 SHALL have port cmd_width_us, input, 16 bits: requested high time in us.
REQ-011 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when an accepted command has an invalid channel.
REQ-012 SHALL have port pwm_out, output, NUM_CH bits: registered servo pulse outputs.
REQ-013 SHALL have port tick_us, output, 1 bit: one-cycle pulse every 1 us.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first tick of each frame.

Function
REQ-015 Prescaler SHALL count 0..CLK_HZ/1_000_000-1 (0..49 at default), asserting tick_us in the cycle it holds its terminal value, then wrap to 0.
REQ-016 Frame counter us_cnt SHALL advance on each tick_us over 0..FRAME_US-1 and wrap to 0.
REQ-017 A command SHALL transfer when cmd_valid && cmd_ready; cmd_ch and cmd_width_us are sampled in that cycle only.
REQ-018 An accepted command with cmd_ch < NUM_CH SHALL write pending[cmd_ch] (clamped per REQ-029/030); with cmd_ch >= NUM_CH it SHALL be dropped and cmd_err pulses the next cycle.
REQ-019 Commit cycle: the cycle where tick_us=1 and us_cnt=FRAME_US-1. In it, active[i] <= pending[i] for all i, and us_cnt wraps.
REQ-020 cmd_ready SHALL be 0 in the commit cycle and 1 in all other non-reset cycles; a command held across the commit cycle is accepted in the next cycle and takes effect at the following commit.
REQ-021 frame_start SHALL be registered, pulsing in the cycle after the commit cycle.
REQ-022 pwm_out[i] SHALL be registered as (us_cnt < active[i]), so it lags the counter by exactly one cycle.
REQ-023 A width of 0 SHALL keep pwm_out[i] at 0; a width >= FRAME_US SHALL keep it constantly 1.
REQ-024 Width changes SHALL never alter the frame in progress: outputs are glitch-free, with at most one rising edge per channel per frame.
REQ-025 Multiple writes to the same channel within one frame SHALL keep the last one only.

Reset
REQ-026 While reset=1, the block SHALL force: prescaler=0, us_cnt=0, pending[i]=active[i]=INIT_US, pwm_out=0, tick_us=0, frame_start=0, cmd_err=0, cmd_ready=0.
REQ-027 On the first cycle after reset deasserts, the block SHALL set cmd_ready=1 and start a new frame at us_cnt=0; frame_start does not pulse for this initial frame.
REQ-028 Reset asserted mid-frame SHALL take effect on the next clock edge and discard pending commands.

Configuration
REQ-029 With macro SERVO_CLAMP_EN defined, accepted widths SHALL be saturated to [MIN_US, MAX_US] before being written to pending.
REQ-030 Without SERVO_CLAMP_EN, accepted widths SHALL be stored unmodified, and REQ-023 governs the extremes.

Structure
REQ-031 Package servo_pkg SHALL hold typedef width_us_t (16-bit), typedef ch_idx_t (3-bit), and the default constants CLK_HZ, FRAME_US, MIN_US, MAX_US and INIT_US.
REQ-032 The prescaler SHALL be a sub-module us_tick_gen (parameter CLK_HZ; ports clk, reset, tick_us).

Verification
REQ-033 Reset release, no commands -> every pwm_out high for 75_000 cycles out of every 1_000_000; tick_us period 50 cycles.
REQ-034 Write ch2=1800 at us_cnt=500 -> current frame ch2 high for 1500 us; next frame high for 1800 us (90_000 cycles); other channels unchanged.
REQ-035 Hold cmd_valid through the commit cycle -> cmd_ready=0 there; accepted the next cycle; applied one frame later.
REQ-036 With SERVO_CLAMP_EN, write 500 to ch0 and 2600 to ch1 -> 1000 us and 2000 us pulses; without it, write 0 -> pwm_out[0] stays 0.
REQ-037 Write cmd_ch=7 -> cmd_err pulses once; all widths unchanged.
REQ-038 Assert reset at us_cnt=1200 for 3 cycles -> pwm_out=0 the next cycle; after release, all channels 1500 us and us_cnt restarts at 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types, default timing constants and the width saturation helper
// for the servo PWM generator.
package servo_pkg;

  typedef logic [15:0] width_us_t;
  typedef logic [2:0]  ch_idx_t;

  localparam int CLK_HZ   = 50_000_000;
  localparam int FRAME_US = 20000;
  localparam int MIN_US   = 1000;
  localparam int MAX_US   = 2000;
  localparam int INIT_US  = 1500;

  function automatic width_us_t clamp_width(width_us_t w, width_us_t lo, width_us_t hi);
    if (w < lo)      return lo;
    else if (w > hi) return hi;
    else             return w;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_HZ/1e6-1 and flags the terminal cycle.
module us_tick_gen #(
  parameter int CLK_HZ = servo_pkg::CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  output logic tick_us
);

  localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          term;

  always_comb begin
    term    = (presc_q == LAST);
    presc_d = term ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Gated so the tick stays low for the whole reset window.
  assign tick_us = term && !reset;

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo PWM generator with frame-synchronous width updates.
// Optional macro SERVO_CLAMP_EN saturates accepted widths to [MIN_US, MAX_US].
module servo_pwm_gen #(
  parameter int CLK_HZ   = servo_pkg::CLK_HZ,
  parameter int NUM_CH   = 5,
  parameter int FRAME_US = servo_pkg::FRAME_US,
  parameter int MIN_US   = servo_pkg::MIN_US,
  parameter int MAX_US   = servo_pkg::MAX_US,
  parameter int INIT_US  = servo_pkg::INIT_US
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_ch,
  input  logic [15:0]       cmd_width_us,
  output logic              cmd_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              tick_us,
  output logic              frame_start
);
  import servo_pkg::width_us_t;
  import servo_pkg::ch_idx_t;
`ifdef SERVO_CLAMP_EN
  import servo_pkg::clamp_width;
`endif

  localparam width_us_t FRAME_LAST = width_us_t'(FRAME_US - 1);
  localparam width_us_t INIT_W     = width_us_t'(INIT_US);

  width_us_t                us_cnt_q, us_cnt_d;
  width_us_t [NUM_CH-1:0]   pending_q, pending_d;
  width_us_t [NUM_CH-1:0]   active_q, active_d;
  logic      [NUM_CH-1:0]   pwm_q, pwm_d;
  logic                     frame_start_q, frame_start_d;
  logic                     cmd_err_q, cmd_err_d;
  logic                     commit, accept, ch_ok;
  width_us_t                wr_width;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .tick_us (tick_us)
  );

  always_comb begin
    commit    = tick_us && (us_cnt_q == FRAME_LAST);
    cmd_ready = !reset && !commit;
    accept    = cmd_valid && cmd_ready;
    ch_ok     = 32'(cmd_ch) < NUM_CH;
`ifdef SERVO_CLAMP_EN
    wr_width  = clamp_width(cmd_width_us, width_us_t'(MIN_US), width_us_t'(MAX_US));
`else
    wr_width  = cmd_width_us;
`endif
    us_cnt_d = us_cnt_q;
    if (tick_us) us_cnt_d = commit ? '0 : us_cnt_q + 16'd1;
    pending_d = pending_q;
    for (int i = 0; i < NUM_CH; i++)
      if (accept && cmd_ch == ch_idx_t'(i)) pending_d[i] = wr_width;
    // Active widths only move at the frame wrap, so a frame never sees a width change.
    active_d = commit ? pending_q : active_q;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = us_cnt_q < active_q[i];
    frame_start_d = commit;
    cmd_err_d     = accept && !ch_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      us_cnt_q      <= '0;
      pending_q     <= {NUM_CH{INIT_W}};
      active_q      <= {NUM_CH{INIT_W}};
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      us_cnt_q      <= us_cnt_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a shrunk clock/frame so whole frames fit the run.
module tb_servo_pwm_gen;

  localparam int CLK_HZ    = 4_000_000;
  localparam int NUM_CH    = 5;
  localparam int FRAME_US  = 300;
  localparam int MIN_US    = 100;
  localparam int MAX_US    = 200;
  localparam int INIT_US   = 150;
  localparam int CPU       = CLK_HZ / 1_000_000;
  localparam int FRAME_CYC = FRAME_US * CPU;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd_ch = '0;
  logic [15:0]       cmd_width_us = '0;
  logic              cmd_ready, cmd_err, tick_us, frame_start;
  logic [NUM_CH-1:0] pwm_out;

  int n_chk = 0;
  int n_fail = 0;
  int model_pending[NUM_CH];
  int model_active[NUM_CH];
  int exp_q[$];
  int c_n = 0;
  int c_off[4];
  int c_ch[4];
  int c_w[4];
  logic chk_err = 1'b0;
  logic exp_err = 1'b0;
  int n;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .FRAME_US(FRAME_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .INIT_US(INIT_US)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ch       (cmd_ch),
    .cmd_width_us (cmd_width_us),
    .cmd_err      (cmd_err),
    .pwm_out      (pwm_out),
    .tick_us      (tick_us),
    .frame_start  (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int store_w(input int w);
`ifdef SERVO_CLAMP_EN
    if (w < MIN_US) return MIN_US;
    if (w > MAX_US) return MAX_US;
`endif
    return w;
  endfunction

  function automatic int hi_cyc(input int a);
    return ((a > FRAME_US) ? FRAME_US : a) * CPU;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      model_pending[i] = INIT_US;
      model_active[i]  = INIT_US;
    end
  endtask

  task automatic wait_frame_start(output int cnt);
    cnt = -1;
    for (int k = 1; k <= 3 * FRAME_CYC; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  // Entered at the negedge of a frame_start cycle; returns at the next one.
  task automatic measure_frame(input string tag);
    int hi[NUM_CH];
    int rises[NUM_CH];
    int ticks, t1, t2;
    logic [NUM_CH-1:0] prev;
    bit ready_exp;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_q.push_back(hi_cyc(model_active[i]));
      hi[i] = 0;
      rises[i] = 0;
    end
    prev = pwm_out;
    ticks = 0; t1 = -1; t2 = -1;
    for (int j = 1; j <= FRAME_CYC; j++) begin
      @(negedge clk);
      if (chk_err) begin
        chk({tag, "_cmd_err"}, 32'(cmd_err), 32'(exp_err));
        chk_err = 1'b0;
      end
      if (j == FRAME_CYC)
        for (int i = 0; i < NUM_CH; i++) model_active[i] = model_pending[i];
      cmd_valid = 1'b0;
      for (int k = 0; k < c_n; k++) begin
        if (c_off[k] == j) begin
          cmd_valid    = 1'b1;
          cmd_ch       = 3'(c_ch[k]);
          cmd_width_us = 16'(c_w[k]);
          ready_exp    = (j != FRAME_CYC - 1);
          chk($sformatf("%s_ready_j%0d", tag, j), 32'(cmd_ready), 32'(ready_exp));
          if (ready_exp) begin
            if (c_ch[k] < NUM_CH) model_pending[c_ch[k]] = store_w(c_w[k]);
            chk_err = 1'b1;
            exp_err = (c_ch[k] >= NUM_CH);
          end
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (pwm_out[i]) hi[i]++;
        if (pwm_out[i] && !prev[i]) rises[i]++;
      end
      prev = pwm_out;
      if (tick_us) begin
        ticks++;
        if (t1 < 0) t1 = j;
        else if (t2 < 0) t2 = j;
      end
      if (j == FRAME_CYC / 2) chk({tag, "_fs_mid"}, 32'(frame_start), 32'd0);
    end
    chk({tag, "_fs_end"}, 32'(frame_start), 32'd1);
    chk({tag, "_ticks"}, 32'(ticks), 32'(FRAME_US));
    chk({tag, "_tick_period"}, 32'(t2 - t1), 32'(CPU));
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("%s_hi%0d", tag, i), 32'(hi[i]), 32'(exp_q.pop_front()));
      chk($sformatf("%s_rises%0d", tag, i), 32'(rises[i] <= 1), 32'd1);
    end
    c_n = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(tick_us), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    wait_frame_start(n);
    chk("first_frame_len", 32'(n), 32'(FRAME_CYC));

    // Mid-frame write to ch2 only shows up in the following frame.
    c_n = 1; c_off[0] = 100 * CPU; c_ch[0] = 2; c_w[0] = 180;
    measure_frame("A");

    c_n = 2;
    c_off[0] = 100; c_ch[0] = 7; c_w[0] = 50;
    c_off[1] = 200; c_ch[1] = 0; c_w[1] = 0;
    measure_frame("B");

    c_n = 3;
    c_off[0] = 100; c_ch[0] = 1; c_w[0] = 260;
    c_off[1] = 300; c_ch[1] = 1; c_w[1] = 400;
    c_off[2] = 500; c_ch[2] = 3; c_w[2] = 50;
    measure_frame("C");

    // Command held across the commit cycle.
    c_n = 2;
    c_off[0] = FRAME_CYC - 1; c_ch[0] = 4; c_w[0] = 120;
    c_off[1] = FRAME_CYC;     c_ch[1] = 4; c_w[1] = 120;
    measure_frame("D");
    measure_frame("E");
    measure_frame("F");

    // Reset mid-frame discards a pending write.
    for (int j = 1; j <= 120 * CPU; j++) begin
      @(negedge clk);
      cmd_valid = (j == 100);
      if (j == 100) begin
        cmd_ch = 3'd1;
        cmd_width_us = 16'd50;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
    chk("mid_rst_tick", 32'(tick_us), 32'd0);
    chk("mid_rst_fs", 32'(frame_start), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_err", 32'(cmd_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
    model_reset();
    chk_err = 1'b0;
    wait_frame_start(n);
    chk("post_rst_frame_len", 32'(n), 32'(FRAME_CYC));
    measure_frame("G");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
